dcache_port_arbiter: RTL

DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

---
 rtl/dcache_port_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/dcache_port_arbiter.sv
// Arbitrates two LSU pipes and a cacop requester onto one in-order dcache port.
// An owner-tag FIFO routes each dcache response back to the requester that issued it.
module dcache_port_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_valid,
  input  logic [73:0] r0_payload,
  output logic        r0_ready,
  output logic        r0_data_ok,
  input  logic        r1_valid,
  input  logic [73:0] r1_payload,
  output logic        r1_ready,
  output logic        r1_data_ok,
  input  logic        c_valid,
  input  logic [73:0] c_payload,
  output logic        c_ready,
  output logic        c_data_ok,
  output logic [31:0] rdata,
  output logic        dc_valid,
  output logic [73:0] dc_payload,
  input  logic        dc_addr_ok,
  input  logic        dc_data_ok,
  input  logic [31:0] dc_rdata,
  output logic        err_orphan
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [1:0] OWN_R0 = 2'd0;
  localparam logic [1:0] OWN_R1 = 2'd1;
  localparam logic [1:0] OWN_C  = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK_R0 = 2'd1,
    LOCK_R1 = 2'd2,
    LOCK_C  = 2'd3
  } lock_e;

  lock_e             lock_q, lock_d;
  logic              rr_last_q, rr_last_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic              err_orphan_q, err_orphan_d;
  logic [1:0]        owner_q [DEPTH];

  logic              full_s;
  logic              hold_s;
  logic [1:0]        lock_owner_s;
  logic              gnt_valid_s;
  logic [1:0]        gnt_owner_s;
  logic              accept_s;
  logic              pop_s;
  logic              orphan_s;
  logic [1:0]        head_owner_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full_s       = (count_q == CNT_W'(DEPTH));
  assign head_owner_s = owner_q[head_q];

  // Grant selection: a held lock pins the grant, otherwise c then round-robin pipes.
  always_comb begin
    hold_s       = 1'b0;
    lock_owner_s = OWN_R0;
    gnt_valid_s  = 1'b0;
    gnt_owner_s  = OWN_R0;
    case (lock_q)
      LOCK_R0: begin hold_s = r0_valid; lock_owner_s = OWN_R0; end
      LOCK_R1: begin hold_s = r1_valid; lock_owner_s = OWN_R1; end
      LOCK_C:  begin hold_s = c_valid;  lock_owner_s = OWN_C;  end
      default: begin hold_s = 1'b0;     lock_owner_s = OWN_R0; end
    endcase
    if (hold_s) begin
      gnt_valid_s = 1'b1;
      gnt_owner_s = lock_owner_s;
    end else if (c_valid) begin
      gnt_valid_s = 1'b1;
      gnt_owner_s = OWN_C;
    end else if (r0_valid && r1_valid) begin
      gnt_valid_s = 1'b1;
      gnt_owner_s = rr_last_q ? OWN_R0 : OWN_R1;
    end else if (r0_valid) begin
      gnt_valid_s = 1'b1;
      gnt_owner_s = OWN_R0;
    end else if (r1_valid) begin
      gnt_valid_s = 1'b1;
      gnt_owner_s = OWN_R1;
    end else begin
      gnt_valid_s = 1'b0;
      gnt_owner_s = OWN_R0;
    end
    if (full_s || reset) begin
      gnt_valid_s = 1'b0;
    end else begin
      gnt_valid_s = gnt_valid_s;
    end
  end

  assign accept_s = gnt_valid_s && dc_addr_ok;
  assign dc_valid = gnt_valid_s;
  assign r0_ready = accept_s && (gnt_owner_s == OWN_R0);
  assign r1_ready = accept_s && (gnt_owner_s == OWN_R1);
  assign c_ready  = accept_s && (gnt_owner_s == OWN_C);

  // Payload mux; zero whenever nothing is presented to the dcache.
  always_comb begin
    dc_payload = 74'd0;
    if (gnt_valid_s) begin
      case (gnt_owner_s)
        OWN_R0:  dc_payload = r0_payload;
        OWN_R1:  dc_payload = r1_payload;
        OWN_C:   dc_payload = c_payload;
        default: dc_payload = 74'd0;
      endcase
    end else begin
      dc_payload = 74'd0;
    end
  end

  assign pop_s      = dc_data_ok && (count_q != CNT_W'(0)) && !reset;
  assign orphan_s   = dc_data_ok && (count_q == CNT_W'(0)) && !reset;
  assign r0_data_ok = pop_s && (head_owner_s == OWN_R0);
  assign r1_data_ok = pop_s && (head_owner_s == OWN_R1);
  assign c_data_ok  = pop_s && (head_owner_s == OWN_C);
  assign rdata      = dc_rdata;
  assign err_orphan = err_orphan_q;

  // Next-state for lock, round-robin pointer, FIFO bookkeeping and the sticky error.
  always_comb begin
    lock_d       = lock_q;
    rr_last_d    = rr_last_q;
    count_d      = count_q;
    head_d       = head_q;
    tail_d       = tail_q;
    err_orphan_d = err_orphan_q || orphan_s;

    // A full FIFO freezes the lock so an interrupted request resumes where it left off.
    if (full_s) begin
      lock_d = lock_q;
    end else if (gnt_valid_s && !dc_addr_ok) begin
      case (gnt_owner_s)
        OWN_R0:  lock_d = LOCK_R0;
        OWN_R1:  lock_d = LOCK_R1;
        OWN_C:   lock_d = LOCK_C;
        default: lock_d = IDLE;
      endcase
    end else begin
      lock_d = IDLE;
    end

    if (accept_s && (gnt_owner_s != OWN_C)) begin
      rr_last_d = gnt_owner_s[0];
    end else begin
      rr_last_d = rr_last_q;
    end

    if (accept_s) begin
      tail_d = next_ptr(tail_q);
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d = next_ptr(head_q);
    end else begin
      head_d = head_q;
    end

    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q       <= IDLE;
      rr_last_q    <= 1'b1;
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      rr_last_q    <= rr_last_d;
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // Owner tag storage; validity is tracked by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      owner_q[tail_q] <= gnt_owner_s;
    end else begin
      owner_q[tail_q] <= owner_q[tail_q];
    end
  end

endmodule
